ro_race_controller: RTL and testbench
=====================================

RO_RACE_CONTROLLER -- requirements
Module: ro_race_controller

Interface
REQ-001 SHALL have parameter RESP_BITS, default 8, number of response bits per challenge.
REQ-002 SHALL have parameter SEL_W, default 4, ring-oscillator select width (16 ROs).
REQ-003 SHALL have parameter SETTLE, default 4, idle cycles between counter clear and race enable.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum RACE cycles per bit.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  request evaluation of challenge; honoured only in IDLE.
REQ-008 SHALL have port challenge  input  RESP_BITS*2*SEL_W  pair selects; bit i: sel_a = [i*2*SEL_W +: SEL_W], sel_b = next SEL_W bits.
REQ-009 SHALL have port race_done  input  2  winner flags from race counter; [0]=RO A reached goal, [1]=RO B; single-cycle pulse.
REQ-010 SHALL have port sel_a, sel_b  output  SEL_W each  RO mux selects for counter inputs 0 and 1.
REQ-011 SHALL have port ro_en  output  1  enables the selected oscillators.
REQ-012 SHALL have port race_clr  output  1  drives the race counter reset.
REQ-013 SHALL have port response  output  RESP_BITS  response word; busy, done, valid, timeout_err, tie_seen  output  1 each.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, SETTLE, RACE, CAPTURE, FINISH.
REQ-015 SHALL, in IDLE with start=1, latch challenge, clear response/flags/valid, set idx=0, enter CLEAR next cycle.
REQ-016 SHALL, in CLEAR, assert race_clr for exactly 1 cycle with sel_a/sel_b from slice idx, then enter SETTLE.
REQ-017 SHALL hold ro_en=0 for SETTLE cycles in SETTLE, then enter RACE.
REQ-018 SHALL assert ro_en=1 throughout RACE and sample race_done every cycle (pulse is not held).
REQ-019 SHALL, on race_done=2'b01, record bit idx = 1; on 2'b10, record 0; enter CAPTURE next cycle.
REQ-020 SHALL, on race_done=2'b11, record 0 and set sticky tie_seen.
REQ-021 SHALL, if RACE reaches TIMEOUT cycles with race_done=0, record 0, set sticky timeout_err, enter CAPTURE.
REQ-022 SHALL, if sel_a==sel_b for slice idx, skip SETTLE/RACE, record 0, set tie_seen.
REQ-023 SHALL, in CAPTURE, deassert ro_en, write bit into response[idx]; if idx==RESP_BITS-1 go FINISH, else idx+1 and CLEAR.
REQ-024 SHALL, in FINISH, pulse done for 1 cycle, set valid (held until next accepted start), return to IDLE.
REQ-025 SHALL assert busy in every state except IDLE; start while busy SHALL be ignored.
REQ-026 SHALL keep sel_a/sel_b stable from CLEAR through CAPTURE of each bit.
REQ-027 SHALL give per-bit latency 1 (CLEAR) + SETTLE + race cycles + 1 (CAPTURE); plus 1 FINISH cycle.

Reset
REQ-028 SHALL on rst force IDLE, idx=0, response=0, ro_en=0, busy=0, done=0, valid=0, timeout_err=0, tie_seen=0, sel_a=sel_b=0.
REQ-029 SHALL assert race_clr whenever rst=1, including reset mid-RACE; rst overrides start.

Structure
REQ-030 SHALL place state enum and default SETTLE/TIMEOUT constants in shared package ro_puf_pkg.
REQ-031 SHALL use one sub-module ro_race_timer (loadable down-counter, zero flag) for SETTLE and TIMEOUT.

Verification
REQ-032 SHALL check: rst=1 2 cycles -> response=0, busy=0, ro_en=0, race_clr=1.
REQ-033 SHALL check: start, race_done=01 on every race -> response=8'hFF, one done pulse, valid=1, flags 0.
REQ-034 SHALL check: alternating 01/10 starting bit0 -> response=8'h55; race_clr 8 single-cycle pulses.
REQ-035 SHALL check: no race_done on bit 2 -> ro_en drops after 1023 RACE cycles, timeout_err=1, bit2=0, run completes.
REQ-036 SHALL check: race_done=11 on bit 0 -> bit0=0, tie_seen=1; slice with sel_a=sel_b=3 -> no ro_en, bit 0.
REQ-037 SHALL check: start while busy ignored; rst mid-RACE -> IDLE next cycle, response=0, ro_en=0.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding and default timing constants for the RO race controller
package ro_puf_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_RACE,
    ST_CAPTURE,
    ST_FINISH
  } state_t;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_TIMEOUT = 1023;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/ro_race_timer.sv
// ro_race_timer: loadable down-counter with zero flag (clk, rst, load/load_val, en -> zero)
module ro_race_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/ro_race_controller.sv
// ro_race_controller: races RO pairs per challenge slice into a response word (start/challenge/race_done in; sel_a/sel_b/ro_en/race_clr to the counter; response/busy/done/valid/timeout_err/tie_seen out)
module ro_race_controller
  import ro_puf_pkg::*;
#(
  parameter int RESP_BITS = 8,
  parameter int SEL_W     = 4,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  input  logic [1:0]                   race_done,
  output logic [SEL_W-1:0]             sel_a,
  output logic [SEL_W-1:0]             sel_b,
  output logic                         ro_en,
  output logic                         race_clr,
  output logic [RESP_BITS-1:0]         response,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic                         timeout_err,
  output logic                         tie_seen
);
  localparam int IW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
  localparam int TW = cnt_w(SETTLE, TIMEOUT);
  state_t state, nxt;
  logic [RESP_BITS*2*SEL_W-1:0] chal_q;
  logic [IW-1:0] idx;
  logic [SEL_W-1:0] slice_a, slice_b;
  logic [TW-1:0] t_val;
  logic bit_q, bit_wr, bit_v, tie_set, to_set, t_load, t_en, t_zero, last, sel_eq;
  assign slice_a  = chal_q[int'(idx)*2*SEL_W +: SEL_W];
  assign slice_b  = chal_q[int'(idx)*2*SEL_W + SEL_W +: SEL_W];
  assign sel_eq   = slice_a == slice_b;
  assign last     = idx == IW'(RESP_BITS - 1);
  assign busy     = state != ST_IDLE;
  assign done     = state == ST_FINISH;
  assign ro_en    = state == ST_RACE;
  // the counter must stay cleared while the controller itself is in reset
  assign race_clr = rst | (state == ST_CLEAR);
  // idx only advances on CAPTURE->CLEAR, so the selects hold for a whole bit
  assign sel_a    = busy ? slice_a : '0;
  assign sel_b    = busy ? slice_b : '0;
  ro_race_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt     = state;
    t_load  = 1'b0;
    t_val   = TW'(SETTLE - 1);
    t_en    = 1'b0;
    bit_wr  = 1'b0;
    bit_v   = 1'b0;
    tie_set = 1'b0;
    to_set  = 1'b0;
    case (state)
      ST_IDLE: nxt = start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: begin
        // identical oscillators cannot race meaningfully: score as a tie
        if (sel_eq) begin
          nxt     = ST_CAPTURE;
          bit_wr  = 1'b1;
          tie_set = 1'b1;
        end else begin
          nxt    = ST_SETTLE;
          t_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (t_zero) begin
          nxt    = ST_RACE;
          t_load = 1'b1;
          t_val  = TW'(TIMEOUT - 1);
        end else t_en = 1'b1;
      end
      ST_RACE: begin
        // a pulse on the final allowed cycle still wins over the timeout
        if (race_done != 2'b00) begin
          nxt     = ST_CAPTURE;
          bit_wr  = 1'b1;
          bit_v   = race_done == 2'b01;
          tie_set = race_done == 2'b11;
        end else if (t_zero) begin
          nxt    = ST_CAPTURE;
          bit_wr = 1'b1;
          to_set = 1'b1;
        end else t_en = 1'b1;
      end
      ST_CAPTURE: nxt = last ? ST_FINISH : ST_CLEAR;
      ST_FINISH: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      chal_q      <= '0;
      idx         <= '0;
      bit_q       <= 1'b0;
      response    <= '0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      tie_seen    <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        chal_q      <= challenge;
        idx         <= '0;
        response    <= '0;
        valid       <= 1'b0;
        timeout_err <= 1'b0;
        tie_seen    <= 1'b0;
      end
      if (bit_wr) bit_q <= bit_v;
      if (tie_set) tie_seen <= 1'b1;
      if (to_set) timeout_err <= 1'b1;
      if (state == ST_CAPTURE) begin
        response[idx] <= bit_q;
        if (!last) idx <= idx + 1'b1;
      end
      if (state == ST_FINISH) valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ro_race_controller.sv
// tb_ro_race_controller: table-driven check of ro_race_controller with a race_done responder
module tb_ro_race_controller;
  logic clk = 1'b0;
  logic rst, start;
  logic [63:0] challenge;
  logic [1:0] race_done;
  logic [3:0] sel_a, sel_b;
  logic ro_en, race_clr, busy, done, valid, timeout_err, tie_seen;
  logic [7:0] response;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [63:0] chal;
    logic [15:0] pat;
    int          d;
    logic        busy_start;
    logic [7:0]  resp;
    logic        to;
    logic        tie;
    int          races;
    int          maxrun;
    int          lat;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  ro_race_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .challenge   (challenge),
    .race_done   (race_done),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .ro_en       (ro_en),
    .race_clr    (race_clr),
    .response    (response),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .timeout_err (timeout_err),
    .tie_seen    (tie_seen)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int n, input vec_t t);
    int clr_hi, clr_rise, races, run, maxrun, lat, done_cnt, b;
    logic clr_prev, ro_prev, sel_bad, v1;
    logic [3:0] ea, eb;
    logic [1:0] p;
    clr_hi = 0; clr_rise = 0; races = 0; run = 0; maxrun = 0; lat = 0; done_cnt = 0;
    clr_prev = 0; ro_prev = 0; sel_bad = 0; v1 = 1'bx;
    @(negedge clk);
    challenge = t.chal;
    start = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      start = 1'b0;
      race_done = 2'b00;
      if (t.busy_start && i == 10) begin
        start = 1'b1;
        challenge = '0;
      end
      if (i == 1) v1 = valid;
      if (race_clr) begin
        clr_hi++;
        if (!clr_prev) clr_rise++;
      end
      clr_prev = race_clr;
      if (ro_en) begin
        if (!ro_prev) races++;
        run++;
        if (run > maxrun) maxrun = run;
        b = clr_rise - 1;
        ea = t.chal[b*8 +: 4];
        eb = t.chal[b*8+4 +: 4];
        if (sel_a !== ea || sel_b !== eb) sel_bad = 1'b1;
        p = t.pat[b*2 +: 2];
        if (p != 2'b00 && run == t.d + 1) race_done = p;
      end else run = 0;
      ro_prev = ro_en;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = i;
      end
      if (lat != 0 && i == lat + 2) break;
    end
    chk($sformatf("v%0d latency", n), lat, t.lat);
    chk($sformatf("v%0d response", n), response, t.resp);
    chk($sformatf("v%0d timeout_err", n), timeout_err, t.to);
    chk($sformatf("v%0d tie_seen", n), tie_seen, t.tie);
    chk($sformatf("v%0d valid_end", n), valid, 1);
    chk($sformatf("v%0d valid_cleared", n), v1, 0);
    chk($sformatf("v%0d busy_end", n), busy, 0);
    chk($sformatf("v%0d done_pulses", n), done_cnt, 1);
    chk($sformatf("v%0d clr_cycles", n), clr_hi, 8);
    chk($sformatf("v%0d clr_pulses", n), clr_rise, 8);
    chk($sformatf("v%0d races", n), races, t.races);
    chk($sformatf("v%0d max_race_len", n), maxrun, t.maxrun);
    chk($sformatf("v%0d sel_stable", n), sel_bad, 0);
  endtask
  initial begin
    int cnt;
    logic prev;
    vecs[0] = '{64'hF7E6D5C4B3A29180, 16'h5555, 0, 1'b0, 8'hFF, 1'b0, 1'b0, 8, 1, 57};
    vecs[1] = '{64'hF7E6D5C4B3A29180, 16'h9999, 2, 1'b0, 8'h55, 1'b0, 1'b0, 8, 3, 73};
    vecs[2] = '{64'hF7E6D5C4B3A29180, 16'h5545, 0, 1'b0, 8'hFB, 1'b1, 1'b0, 8, 1023, 1079};
    vecs[3] = '{64'hF7E6D5C4B3A29180, 16'h5557, 0, 1'b0, 8'hFE, 1'b0, 1'b1, 8, 1, 57};
    vecs[4] = '{64'hF7E633C4B3A29180, 16'h5555, 0, 1'b0, 8'hDF, 1'b0, 1'b1, 7, 1, 52};
    vecs[5] = '{64'hF7E6D5C4B3A29180, 16'hAAAA, 0, 1'b1, 8'h00, 1'b0, 1'b0, 8, 1, 57};
    rst = 1'b1;
    start = 1'b0;
    race_done = 2'b00;
    challenge = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst response", response, 0);
    chk("rst busy", busy, 0);
    chk("rst ro_en", ro_en, 0);
    chk("rst race_clr", race_clr, 1);
    chk("rst done", done, 0);
    chk("rst valid", valid, 0);
    chk("rst flags", {timeout_err, tie_seen}, 0);
    chk("rst sel", {sel_a, sel_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle race_clr", race_clr, 0);
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);
    repeat (3) @(negedge clk);
    chk("valid held", valid, 1);
    challenge = 64'hF7E6D5C4B3A29180;
    start = 1'b1;
    cnt = 0;
    prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = 1'b0;
      race_done = 2'b00;
      if (ro_en) begin
        if (!prev) cnt++;
        if (cnt == 4) break;
        race_done = 2'b01;
      end
      prev = ro_en;
    end
    chk("pre-rst ro_en", ro_en, 1);
    chk("pre-rst response", response, 8'h07);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-race rst busy", busy, 0);
    chk("mid-race rst ro_en", ro_en, 0);
    chk("mid-race rst response", response, 0);
    chk("mid-race rst race_clr", race_clr, 1);
    chk("mid-race rst valid", valid, 0);
    start = 1'b1;
    @(negedge clk);
    chk("rst over start busy", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post-rst busy", busy, 0);
    chk("post-rst race_clr", race_clr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
